// File: rtl/branch_scheduler.sv
// Branch reservation station: compacting in-order queue with CDB wakeup and oldest-ready issue.
// Optional zero-cycle CDB wakeup of issue candidates is enabled by defining BRANCH_SCHED_CDB_BYPASS_EN.
module branch_scheduler #(
    parameter int XLEN          = 32,
    parameter int ROB_TAG_WIDTH = 4,
    parameter int N_ENTRIES     = 4,
    parameter int INFO_WIDTH    = 3*XLEN+6
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic                         dispatch_valid,
    output logic                         dispatch_ready,
    input  logic [XLEN-1:0]              dispatch_v1,
    input  logic [ROB_TAG_WIDTH-1:0]     dispatch_q1,
    input  logic                         dispatch_q1_pending,
    input  logic [XLEN-1:0]              dispatch_v2,
    input  logic [ROB_TAG_WIDTH-1:0]     dispatch_q2,
    input  logic                         dispatch_q2_pending,
    input  logic [ROB_TAG_WIDTH-1:0]     dispatch_rob_tag,
    input  logic [INFO_WIDTH-1:0]        dispatch_info,
    input  logic                         cdb_valid,
    input  logic [ROB_TAG_WIDTH-1:0]     cdb_tag,
    input  logic [XLEN-1:0]              cdb_data,
    output logic                         ready_to_execute,
    input  logic                         accept,
    output logic [XLEN-1:0]              issue_v1,
    output logic [XLEN-1:0]              issue_v2,
    output logic [ROB_TAG_WIDTH-1:0]     issue_rob_tag,
    output logic [INFO_WIDTH-1:0]        issue_info,
    output logic [$clog2(N_ENTRIES):0]   occupancy
);

    localparam int IW = $clog2(N_ENTRIES);
    localparam int CW = IW + 1;

    logic [XLEN-1:0]          v1_q   [N_ENTRIES];
    logic [XLEN-1:0]          v1_d   [N_ENTRIES];
    logic [XLEN-1:0]          v2_q   [N_ENTRIES];
    logic [XLEN-1:0]          v2_d   [N_ENTRIES];
    logic [ROB_TAG_WIDTH-1:0] q1_q   [N_ENTRIES];
    logic [ROB_TAG_WIDTH-1:0] q1_d   [N_ENTRIES];
    logic [ROB_TAG_WIDTH-1:0] q2_q   [N_ENTRIES];
    logic [ROB_TAG_WIDTH-1:0] q2_d   [N_ENTRIES];
    logic [ROB_TAG_WIDTH-1:0] tag_q  [N_ENTRIES];
    logic [ROB_TAG_WIDTH-1:0] tag_d  [N_ENTRIES];
    logic [INFO_WIDTH-1:0]    info_q [N_ENTRIES];
    logic [INFO_WIDTH-1:0]    info_d [N_ENTRIES];
    logic [N_ENTRIES-1:0]     p1_q, p1_d, p2_q, p2_d;
    logic [CW-1:0]            count_q, count_d;

    logic [XLEN-1:0]          v1_c [N_ENTRIES];
    logic [XLEN-1:0]          v2_c [N_ENTRIES];
    logic [N_ENTRIES-1:0]     p1_c, p2_c;
    logic [N_ENTRIES-1:0]     slot_valid;
    logic [N_ENTRIES-1:0]     slot_ready;
    logic [XLEN-1:0]          op1 [N_ENTRIES];
    logic [XLEN-1:0]          op2 [N_ENTRIES];

    logic [IW-1:0]            sel;
    logic                     found;
    logic                     issue_fire;
    logic                     dispatch_fire;
    logic [CW-1:0]            base;
    logic [XLEN-1:0]          dv1, dv2;
    logic                     dp1, dp2;

    // Stored operands as they look after this cycle's CDB broadcast has been captured.
    always_comb begin
        for (int i = 0; i < N_ENTRIES; i++) begin
            v1_c[i]       = v1_q[i];
            v2_c[i]       = v2_q[i];
            p1_c[i]       = p1_q[i];
            p2_c[i]       = p2_q[i];
            slot_valid[i] = (count_q > CW'(i));
            if (cdb_valid && p1_q[i] && (q1_q[i] == cdb_tag)) begin
                v1_c[i] = cdb_data;
                p1_c[i] = 1'b0;
            end
            if (cdb_valid && p2_q[i] && (q2_q[i] == cdb_tag)) begin
                v2_c[i] = cdb_data;
                p2_c[i] = 1'b0;
            end
        end
    end

    // Eligibility: registered pending bits, or the CDB-captured view when bypass is built in.
    always_comb begin
        for (int i = 0; i < N_ENTRIES; i++) begin
`ifdef BRANCH_SCHED_CDB_BYPASS_EN
            slot_ready[i] = slot_valid[i] && !p1_c[i] && !p2_c[i];
            op1[i]        = v1_c[i];
            op2[i]        = v2_c[i];
`else
            slot_ready[i] = slot_valid[i] && !p1_q[i] && !p2_q[i];
            op1[i]        = v1_q[i];
            op2[i]        = v2_q[i];
`endif
        end
    end

    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (slot_ready[i] && !found) begin
                sel   = IW'(i);
                found = 1'b1;
            end
        end
    end

    assign ready_to_execute = found;
    assign issue_v1         = found ? op1[sel]    : '0;
    assign issue_v2         = found ? op2[sel]    : '0;
    assign issue_rob_tag    = found ? tag_q[sel]  : '0;
    assign issue_info       = found ? info_q[sel] : '0;
    assign occupancy        = count_q;
    assign dispatch_ready   = (count_q < CW'(N_ENTRIES));
    assign issue_fire       = found && accept;
    assign dispatch_fire    = dispatch_valid && dispatch_ready;

    // A dispatching operand can be woken by the broadcast of the same cycle.
    always_comb begin
        dv1 = dispatch_v1;
        dp1 = dispatch_q1_pending;
        dv2 = dispatch_v2;
        dp2 = dispatch_q2_pending;
        if (cdb_valid && dispatch_q1_pending && (dispatch_q1 == cdb_tag)) begin
            dv1 = cdb_data;
            dp1 = 1'b0;
        end
        if (cdb_valid && dispatch_q2_pending && (dispatch_q2 == cdb_tag)) begin
            dv2 = cdb_data;
            dp2 = 1'b0;
        end
    end

    // Compact over the issued slot first, then append the dispatch behind the survivors.
    always_comb begin
        for (int j = 0; j < N_ENTRIES; j++) begin
            v1_d[j]   = v1_c[j];
            v2_d[j]   = v2_c[j];
            p1_d[j]   = p1_c[j];
            p2_d[j]   = p2_c[j];
            q1_d[j]   = q1_q[j];
            q2_d[j]   = q2_q[j];
            tag_d[j]  = tag_q[j];
            info_d[j] = info_q[j];
        end
        base = count_q;
        if (issue_fire) begin
            base = count_q - CW'(1);
            for (int j = 0; j < N_ENTRIES-1; j++) begin
                if (j >= int'(sel)) begin
                    v1_d[j]   = v1_c[j+1];
                    v2_d[j]   = v2_c[j+1];
                    p1_d[j]   = p1_c[j+1];
                    p2_d[j]   = p2_c[j+1];
                    q1_d[j]   = q1_q[j+1];
                    q2_d[j]   = q2_q[j+1];
                    tag_d[j]  = tag_q[j+1];
                    info_d[j] = info_q[j+1];
                end
            end
        end
        if (dispatch_fire) begin
            for (int j = 0; j < N_ENTRIES; j++) begin
                if (base == CW'(j)) begin
                    v1_d[j]   = dv1;
                    v2_d[j]   = dv2;
                    p1_d[j]   = dp1;
                    p2_d[j]   = dp2;
                    q1_d[j]   = dispatch_q1;
                    q2_d[j]   = dispatch_q2;
                    tag_d[j]  = dispatch_rob_tag;
                    info_d[j] = dispatch_info;
                end
            end
        end
        count_d = base + CW'(dispatch_fire);
        if (flush) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            p1_q    <= '0;
            p2_q    <= '0;
            for (int j = 0; j < N_ENTRIES; j++) begin
                v1_q[j]   <= '0;
                v2_q[j]   <= '0;
                q1_q[j]   <= '0;
                q2_q[j]   <= '0;
                tag_q[j]  <= '0;
                info_q[j] <= '0;
            end
        end else begin
            count_q <= count_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            for (int j = 0; j < N_ENTRIES; j++) begin
                v1_q[j]   <= v1_d[j];
                v2_q[j]   <= v2_d[j];
                q1_q[j]   <= q1_d[j];
                q2_q[j]   <= q2_d[j];
                tag_q[j]  <= tag_d[j];
                info_q[j] <= info_d[j];
            end
        end
    end

endmodule
